// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared memory-access encodings for the core's memory path
//
// Holds the func3 size encodings, the arbiter state type and the requester
// owner encoding. Imported by mem_align_chk, mem_port_arbiter and the LSU.

package riscv_mem_pkg;

    localparam logic [2:0] SZ_B       = 3'b000;
    localparam logic [2:0] SZ_H       = 3'b001;
    localparam logic [2:0] SZ_W       = 3'b010;
    localparam logic [2:0] SZ_D       = 3'b011;
    localparam logic [2:0] SZ_BU      = 3'b100;
    localparam logic [2:0] SZ_HU      = 3'b101;
    localparam logic [2:0] SZ_WU      = 3'b110;
    localparam logic [2:0] SZ_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_align_chk.sv
// rtl/mem_align_chk.sv - combinational size/address legality check
//
// Ports:
//   is_fetch  in   1  access is an instruction fetch (always a word access)
//   size      in   3  func3 size encoding (ignored for fetch)
//   addr_lsb  in   3  low three address bits
//   aligned   out  1  1 = access is legal and naturally aligned

module mem_align_chk
    import riscv_mem_pkg::*;
(
    input  logic       is_fetch,
    input  logic [2:0] size,
    input  logic [2:0] addr_lsb,
    output logic       aligned
);

    always_comb begin
        aligned = 1'b0;
        if (is_fetch) begin
            aligned = (addr_lsb[1:0] == 2'b00);
        end else begin
            case (size)
                SZ_B, SZ_BU: aligned = 1'b1;
                SZ_H, SZ_HU: aligned = ~addr_lsb[0];
                SZ_W, SZ_WU: aligned = (addr_lsb[1:0] == 2'b00);
                SZ_D:        aligned = (addr_lsb == 3'b000);
                default:     aligned = 1'b0;   // SZ_ILLEGAL
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding fetch/data arbiter for one memory port
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   if_req/if_addr             fetch request (level, held until if_done)
//   if_done/if_rdata           fetch completion pulse and 32-bit instruction
//   dm_req/dm_we/dm_size/
//   dm_addr/dm_wdata           data request (level, held until dm_done)
//   dm_done/dm_rdata           data completion pulse and raw load data
//   mem_req/mem_we/mem_size/
//   mem_addr/mem_wdata         memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata  memory grant and response
//   stall                      datapath hold while a request is outstanding
//   err                        alignment or watchdog error, with the owner's done

module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_we_q;
    logic [2:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              any_req;
    logic              is_fetch;
    logic              aligned;
    logic              timeout_hit;
    logic              abort;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;

    // Data has fixed priority over fetch; a fetch is always a word load.
    assign any_req  = dm_req | if_req;
    assign is_fetch = ~dm_req;
    assign req_size = dm_req ? dm_size : SZ_W;
    assign req_addr = dm_req ? dm_addr : if_addr;

    mem_align_chk u_align (
        .is_fetch (is_fetch),
        .size     (req_size),
        .addr_lsb (req_addr[2:0]),
        .aligned  (aligned)
    );

    // The current REQ/RESP cycle is the TIMEOUT-th one. A response arriving
    // on that very cycle still completes normally; a grant does not.
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));
    assign abort       = timeout_hit &&
                         ((state_q == REQ) || ((state_q == RESP) && !mem_rvalid));

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        if_done = 1'b0;
        dm_done = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: if (any_req) state_d = aligned ? REQ : DONE;
            REQ: begin
                mem_req = 1'b1;
                if (abort)        state_d = DONE;
                else if (mem_gnt) state_d = RESP;
            end
            RESP: if (mem_rvalid || abort) state_d = DONE;
            DONE: begin
                if_done = (owner_q == OWN_IF);
                dm_done = (owner_q == OWN_DM);
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (any_req) begin
                        owner_q <= dm_req ? OWN_DM : OWN_IF;
                        err_q   <= ~aligned;
                        rdata_q <= '0;
                        if (aligned) begin
                            mem_we_q    <= dm_req & dm_we;
                            mem_size_q  <= req_size;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= dm_req ? dm_wdata : '0;
                        end
                    end
                end
                REQ, RESP: begin
                    if (TIMEOUT != 0) cnt_q <= cnt_q + CNT_W'(1);
                    if (abort) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if ((state_q == RESP) && mem_rvalid) begin
                        rdata_q <= (owner_q == OWN_DM) ? mem_rdata
                                                       : DATA_W'(mem_rdata[31:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = rdata_q[31:0];
    assign dm_rdata  = rdata_q;

    assign stall = reset & ((if_req & ~if_done) | (dm_req & ~dm_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [2:0]    dm_size;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall), .err(err)
    );

    // One access as seen by the bench: request, memory behaviour (g grant
    // wait cycles, r response wait cycles) and the predicted timeline.
    typedef struct {
        bit          is_dm;
        bit          we;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          g;
        int          r;
        int          t0;
        bit          bad;
        bit          err;
        int          d;
        int          req_last;
        int          gnt_at;
        int          rv_at;
    } acc_t;

    int n_chk = 0;
    int n_err = 0;
    int cur_k = 0;
    bit chk_en = 0;

    bit          e_mem_req, e_if_done, e_dm_done, e_err, e_stall;
    bit          e_fld, e_wchk, e_we, e_if_rd_chk, e_dm_rd_chk;
    logic [2:0]  e_size;
    logic [63:0] e_addr, e_wdata, e_dm_rd;
    logic [31:0] e_if_rd;

    int          obs_dm_k, obs_if_k;
    bit          obs_dm_err, obs_if_err;
    logic [63:0] obs_dm_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cur_k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", 64'(mem_req), 64'(e_mem_req));
            check("if_done", 64'(if_done), 64'(e_if_done));
            check("dm_done", 64'(dm_done), 64'(e_dm_done));
            check("err", 64'(err), 64'(e_err));
            check("stall", 64'(stall), 64'(e_stall));
            if (e_fld) begin
                check("mem_we", 64'(mem_we), 64'(e_we));
                check("mem_size", 64'(mem_size), 64'(e_size));
                check("mem_addr", mem_addr, e_addr);
                if (e_wchk) check("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_dm_rd_chk) check("dm_rdata", dm_rdata, e_dm_rd);
            if (e_if_rd_chk) check("if_rdata", 64'(if_rdata), 64'(e_if_rd));
            if (dm_done && obs_dm_k < 0) begin
                obs_dm_k = cur_k; obs_dm_err = err; obs_dm_rd = dm_rdata;
            end
            if (if_done && obs_if_k < 0) begin
                obs_if_k = cur_k; obs_if_err = err;
            end
        end
    end

    function automatic acc_t mk(bit is_dm, bit we, logic [2:0] size, logic [63:0] addr,
                                logic [63:0] wdata, logic [63:0] rdata, int g, int r);
        acc_t a;
        a.is_dm = is_dm; a.we = is_dm & we; a.size = is_dm ? size : 3'b010;
        a.addr = addr; a.wdata = wdata; a.rdata = rdata; a.g = g; a.r = r;
        a.t0 = 0; a.bad = 0; a.err = 0; a.d = 0; a.req_last = -1; a.gnt_at = -1; a.rv_at = -1;
        return a;
    endfunction

    // Timeline from the rules: issue cycle t0, REQ from t0+1, at most T
    // cycles in REQ+RESP, done the cycle after; misaligned -> done at t0+1.
    function automatic acc_t plan(acc_t a, int t0);
        int nb;
        a.t0 = t0;
        nb = a.is_dm ? (1 << a.size[1:0]) : 4;
        a.bad = (a.is_dm && a.size == 3'b111) || ((a.addr % 64'(nb)) != 64'd0);
        a.req_last = -1; a.gnt_at = -1; a.rv_at = -1;
        if (a.bad) begin
            a.d = t0 + 1; a.err = 1;
        end else if (a.g + 1 >= T) begin
            a.d = t0 + T + 1; a.err = 1; a.req_last = t0 + T; a.gnt_at = t0 + 1 + a.g;
        end else if (a.g + a.r + 2 <= T) begin
            a.d = t0 + a.g + a.r + 3; a.err = 0;
            a.req_last = t0 + 1 + a.g; a.gnt_at = t0 + 1 + a.g; a.rv_at = t0 + 2 + a.g + a.r;
        end else begin
            a.d = t0 + T + 1; a.err = 1;
            a.req_last = t0 + 1 + a.g; a.gnt_at = t0 + 1 + a.g;
            if (2 + a.g + a.r <= T + 1) a.rv_at = t0 + 2 + a.g + a.r;
        end
        return a;
    endfunction

    task automatic exp_quiet();
        e_mem_req = 0; e_if_done = 0; e_dm_done = 0; e_err = 0; e_stall = 0;
        e_fld = 0; e_wchk = 0; e_if_rd_chk = 0; e_dm_rd_chk = 0;
    endtask

    task automatic exp_zero_fields();
        e_fld = 1; e_wchk = 1; e_we = 0; e_size = 3'b000; e_addr = '0; e_wdata = '0;
        e_dm_rd_chk = 1; e_dm_rd = '0; e_if_rd_chk = 1; e_if_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input acc_t dm, input acc_t fi, input bit use_dm, input bit use_if);
        int last;
        if (use_dm) dm = plan(dm, 0);
        if (use_if) fi = plan(fi, use_dm ? dm.d + 1 : 0);
        last = use_if ? fi.d : dm.d;
        obs_dm_k = -1; obs_if_k = -1;
        dm_we = dm.we; dm_size = dm.size; dm_addr = dm.addr; dm_wdata = dm.wdata;
        if_addr = fi.addr;
        for (int k = 0; k <= last + 2; k++) begin
            cur_k = k;
            dm_req = use_dm && k <= dm.d;
            if_req = use_if && k <= fi.d;
            mem_gnt = (use_dm && k == dm.gnt_at) || (use_if && k == fi.gnt_at);
            mem_rvalid = 0;
            mem_rdata = {$urandom, $urandom};
            if (use_dm && (k == dm.rv_at || (dm.err && k == dm.d + 1))) begin
                mem_rvalid = 1;
                if (k == dm.rv_at) mem_rdata = dm.rdata;
            end
            if (use_if && (k == fi.rv_at || (fi.err && k == fi.d + 1))) begin
                mem_rvalid = 1;
                if (k == fi.rv_at) mem_rdata = fi.rdata;
            end
            exp_quiet();
            if (use_dm && !dm.bad && k > dm.t0 && k <= dm.req_last) begin
                e_mem_req = 1; e_fld = 1; e_we = dm.we; e_size = dm.size;
                e_addr = dm.addr; e_wchk = 1; e_wdata = dm.wdata;
            end
            if (use_if && !fi.bad && k > fi.t0 && k <= fi.req_last) begin
                e_mem_req = 1; e_fld = 1; e_we = 0; e_size = 3'b010; e_addr = fi.addr;
            end
            e_dm_done = use_dm && k == dm.d;
            e_if_done = use_if && k == fi.d;
            e_err = (e_dm_done && dm.err) || (e_if_done && fi.err);
            e_dm_rd_chk = e_dm_done; e_dm_rd = dm.err ? 64'd0 : dm.rdata;
            e_if_rd_chk = e_if_done; e_if_rd = fi.err ? 32'd0 : fi.rdata[31:0];
            e_stall = (if_req && !e_if_done) || (dm_req && !e_dm_done);
            step();
        end
    endtask

    task automatic reset_mid();
        obs_dm_k = -1; obs_if_k = -1;
        dm_we = 0; dm_size = 3'b011; dm_addr = 64'h200; dm_wdata = 64'h1234;
        if_req = 0; mem_gnt = 0; mem_rvalid = 0;
        cur_k = 0; dm_req = 1; exp_quiet(); e_stall = 1; step();
        cur_k = 1; mem_gnt = 1; exp_quiet(); e_stall = 1; e_mem_req = 1; e_fld = 1;
        e_we = 0; e_size = 3'b011; e_addr = 64'h200; step();
        cur_k = 2; mem_gnt = 0; reset = 0; exp_quiet(); step();
        cur_k = 3; reset = 1; dm_req = 0; mem_rvalid = 1; exp_quiet(); exp_zero_fields(); step();
        cur_k = 4; mem_rvalid = 0; exp_quiet(); step();
        check("rst_mid_no_done", 64'(obs_dm_k), 64'(-1));
    endtask

    initial begin
        acc_t a, b, none;
        none = mk(0, 0, 3'b010, 64'h0, 64'h0, 64'h0, 0, 0);
        reset = 0; if_req = 1; dm_req = 1; if_addr = '0; dm_we = 0; dm_size = 3'b010;
        dm_addr = '0; dm_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        obs_dm_k = -1; obs_if_k = -1;
        exp_quiet();
        step();
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            cur_k = i; exp_quiet(); exp_zero_fields(); step();
        end
        reset = 1; if_req = 0; dm_req = 0;
        for (int i = 0; i < 2; i++) begin
            cur_k = i; exp_quiet(); exp_zero_fields(); step();
        end

        a = mk(1, 0, 3'b011, 64'h100, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 0);
        run(a, none, 1, 0);
        check("tp_load_done_cycle", 64'(obs_dm_k), 64'd3);
        check("tp_load_rdata", obs_dm_rd, 64'hDEADBEEF_CAFEF00D);

        a = mk(1, 1, 3'b000, 64'h7, 64'h55, 64'h0, 0, 0);
        b = mk(0, 0, 3'b010, 64'h0, 64'h0, 64'h0000_0000_0000_0013, 0, 0);
        run(a, b, 1, 1);
        check("tp_dual_dm_cycle", 64'(obs_dm_k), 64'd3);
        check("tp_dual_if_cycle", 64'(obs_if_k), 64'd7);

        a = mk(1, 0, 3'b010, 64'h102, 64'h0, 64'h0, 0, 0);
        run(a, none, 1, 0);
        check("tp_misalign_dm_cycle", 64'(obs_dm_k), 64'd1);
        check("tp_misalign_dm_err", 64'(obs_dm_err), 64'd1);

        b = mk(0, 0, 3'b010, 64'h6, 64'h0, 64'h0, 0, 0);
        run(none, b, 0, 1);
        check("tp_misalign_if_cycle", 64'(obs_if_k), 64'd1);
        check("tp_misalign_if_err", 64'(obs_if_err), 64'd1);

        a = mk(1, 0, 3'b011, 64'h40, 64'h0, 64'h0, 0, 20);
        run(a, none, 1, 0);
        check("tp_timeout_cycle", 64'(obs_dm_k), 64'd5);
        check("tp_timeout_err", 64'(obs_dm_err), 64'd1);

        reset_mid();
        b = mk(0, 0, 3'b010, 64'h80, 64'h0, 64'hFFFF_FFFF_0000_0073, 0, 1);
        run(none, b, 0, 1);
        check("tp_after_reset_fetch", 64'(obs_if_k), 64'd4);

        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            a = mk(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) a.addr[2:0] = 3'b000;
            b = mk(0, 0, 3'b010, {$urandom, $urandom}, 64'h0, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 4));
            if ($urandom_range(0, 3) != 0) b.addr[1:0] = 2'b00;
            run(a, b, sel != 1, sel != 0);
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
